// File: rtl/axis_i2s_tx.sv
// AXI-Stream to Philips I2S transmitter with one-entry holding register.
// Serial clocks derived from mclk; silence and underrun flag when starved.
module axis_i2s_tx #(
    parameter int BCLK_DIV = 8,
    parameter int DATA_W   = 32,
    parameter int UCNT_W   = 16
) (
    input  logic              mclk,
    input  logic              mclk_rstn,
    input  logic              enable,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              bclk,
    output logic              lrclk,
    output logic              sda,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);
    localparam int SLOT  = DATA_W / 2;
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LR_LO    = BIT_W'(SLOT - 1);
    localparam logic [BIT_W-1:0] LR_HI    = BIT_W'(DATA_W - 2);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              underrun_q, underrun_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;

    logic fall;
    logic frame_start;
    logic accept;
    logic unused_tlast;

    assign unused_tlast = s_axis_tlast;

    assign s_axis_tready = !hold_valid_q;
    assign accept        = s_axis_tvalid && !hold_valid_q;
    assign fall          = enable && (div_q == DIV_MAX);

    always_comb begin
        div_d        = '0;
        bitcnt_d     = BIT_MAX;
        shreg_d      = '0;
        lrclk_d      = 1'b0;
        frame_start  = 1'b0;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        underrun_d   = 1'b0;
        ucnt_d       = ucnt_q;

        if (enable) begin
            div_d    = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
            bitcnt_d = bitcnt_q;
            shreg_d  = shreg_q;
            lrclk_d  = lrclk_q;
            if (fall) begin
                bitcnt_d    = (bitcnt_q == BIT_MAX) ? '0 : bitcnt_q + 1'b1;
                lrclk_d     = (bitcnt_d >= LR_LO) && (bitcnt_d <= LR_HI);
                frame_start = (bitcnt_d == '0);
                shreg_d     = {shreg_q[DATA_W-2:0], 1'b0};
            end
        end

        // Frame start consumes the held beat or substitutes silence.
        if (frame_start) begin
            if (hold_valid_q) begin
                shreg_d      = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                shreg_d    = '0;
                underrun_d = 1'b1;
                if (!(&ucnt_q)) ucnt_d = ucnt_q + 1'b1;
            end
        end

        if (accept) begin
            hold_d       = s_axis_tdata;
            hold_valid_d = 1'b1;
        end

        bclk_d = (div_d >= DIV_HALF);
    end

    always_ff @(posedge mclk or negedge mclk_rstn) begin
        if (!mclk_rstn) begin
            div_q        <= '0;
            bitcnt_q     <= BIT_MAX;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b0;
            underrun_q   <= 1'b0;
            ucnt_q       <= '0;
        end else begin
            div_q        <= div_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            underrun_q   <= underrun_d;
            ucnt_q       <= ucnt_d;
        end
    end

    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sda          = shreg_q[DATA_W-1];
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Directed self-checking bench for axis_i2s_tx.
// Serial data is captured on each bclk rising edge and reassembled.
module tb_axis_i2s_tx;
    logic        mclk = 1'b0;
    logic        mclk_rstn;
    logic        enable;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        bclk;
    logic        lrclk;
    logic        sda;
    logic        underrun;
    logic [1:0]  underrun_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ur_seen = 0;

    logic cap_sda [0:127];
    logic cap_lr  [0:127];
    int   cap_cyc [0:127];

    axis_i2s_tx #(
        .BCLK_DIV(8),
        .DATA_W  (32),
        .UCNT_W  (2)
    ) dut (
        .mclk         (mclk),
        .mclk_rstn    (mclk_rstn),
        .enable       (enable),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sda          (sda),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    always @(negedge mclk) if (underrun === 1'b1) ur_seen <= ur_seen + 1;

    function automatic logic [31:0] word_at(input int base);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], cap_sda[base+i]};
        return w;
    endfunction

    function automatic logic [31:0] lr_at(input int base);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], cap_lr[base+i]};
        return w;
    endfunction

    task automatic capture(input int n);
        logic p;
        int t;
        p = bclk;
        for (int i = 0; i < n; i++) begin
            t = 0;
            @(negedge mclk);
            while (!(bclk && !p) && t < 64) begin
                p = bclk;
                @(negedge mclk);
                t++;
            end
            p = bclk;
            if (t >= 64) begin
                checks++;
                errors++;
                $display("FAIL capture_timeout rise %0d: no bclk edge in 64 cycles", i);
                return;
            end
            cap_sda[i] = sda;
            cap_lr[i]  = lrclk;
            cap_cyc[i] = cyc;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, output int acc);
        int t = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && t < 600) begin
            @(negedge mclk);
            t++;
        end
        if (t >= 600) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tready stayed 0 for beat %h", d);
        end
        acc = cyc + 1;
        @(negedge mclk);
    endtask

    task automatic test_reset();
        mclk_rstn     = 1'b0;
        enable        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(negedge mclk);
        mclk_rstn = 1'b1;
        @(negedge mclk);
        checks++;
        if ({bclk, lrclk, sda, underrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_lines: got %b want 0000", {bclk, lrclk, sda, underrun});
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b want 1", s_axis_tready);
        end
        checks++;
        if (underrun_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_ucnt: got %0d want 0", underrun_cnt);
        end
    endtask

    task automatic test_single_frame();
        int acc, c0;
        send_beat(32'hA5A5_0F0F, acc);
        s_axis_tvalid = 1'b0;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL single_held: tready got %b want 0", s_axis_tready);
        end
        c0 = cyc;
        enable = 1'b1;
        capture(33);
        enable = 1'b0;
        checks++;
        if (cap_cyc[1] !== c0 + 12) begin
            errors++;
            $display("FAIL single_latency: first bit rise at %0d want %0d", cap_cyc[1], c0 + 12);
        end
        checks++;
        if (cap_cyc[2] - cap_cyc[1] !== 8) begin
            errors++;
            $display("FAIL bclk_period: got %0d want 8", cap_cyc[2] - cap_cyc[1]);
        end
        checks++;
        if (word_at(1) !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL single_data: got %h want a5a50f0f", word_at(1));
        end
        checks++;
        if (lr_at(1) !== 32'h0001_FFFE) begin
            errors++;
            $display("FAIL single_lrclk: got %h want 0001fffe", lr_at(1));
        end
        @(negedge mclk);
        checks++;
        if (ur_seen !== 0 || underrun_cnt !== 2'd0) begin
            errors++;
            $display("FAIL single_underrun: pulses %0d cnt %0d want 0 0", ur_seen, underrun_cnt);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL single_freed: tready got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2, c0, ur0;
        ur0 = ur_seen;
        c0 = cyc;
        enable = 1'b1;
        fork
            begin
                send_beat(32'h0001_8000, a0);
                send_beat(32'h7FFF_FFFF, a1);
                send_beat(32'h8000_0001, a2);
                s_axis_tvalid = 1'b0;
            end
            capture(97);
        join
        enable = 1'b0;
        checks++;
        if (a0 !== c0 + 1 || a1 !== c0 + 9) begin
            errors++;
            $display("FAIL b2b_first_accepts: got %0d %0d want %0d %0d", a0, a1, c0 + 1, c0 + 9);
        end
        checks++;
        if (a2 - a1 !== 256) begin
            errors++;
            $display("FAIL b2b_rate: accept spacing %0d want 256", a2 - a1);
        end
        checks++;
        if (word_at(1) !== 32'h0001_8000) begin
            errors++;
            $display("FAIL b2b_frame0: got %h want 00018000", word_at(1));
        end
        checks++;
        if (word_at(33) !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL b2b_frame1: got %h want 7fffffff", word_at(33));
        end
        checks++;
        if (word_at(65) !== 32'h8000_0001) begin
            errors++;
            $display("FAIL b2b_frame2: got %h want 80000001", word_at(65));
        end
        checks++;
        if (lr_at(33) !== 32'h0001_FFFE) begin
            errors++;
            $display("FAIL b2b_lrclk: got %h want 0001fffe", lr_at(33));
        end
        @(negedge mclk);
        checks++;
        if (ur_seen !== ur0) begin
            errors++;
            $display("FAIL b2b_underrun: pulses %0d want %0d", ur_seen, ur0);
        end
    endtask

    task automatic test_underrun();
        int exp_u [4] = '{1, 2, 3, 3};
        int pc [4];
        int c0, t, sda_bad;
        mclk_rstn = 1'b0;
        @(negedge mclk);
        mclk_rstn = 1'b1;
        @(negedge mclk);
        sda_bad = 0;
        c0 = cyc;
        enable = 1'b1;
        for (int p = 0; p < 4; p++) begin
            t = 0;
            pc[p] = -1;
            while (t < 300) begin
                @(negedge mclk);
                t++;
                if (sda !== 1'b0) sda_bad++;
                if (underrun === 1'b1) break;
            end
            checks++;
            if (underrun !== 1'b1) begin
                errors++;
                $display("FAIL underrun_pulse %0d: not seen within 300 cycles", p);
            end else begin
                pc[p] = cyc;
            end
            checks++;
            if (underrun_cnt !== 2'(exp_u[p])) begin
                errors++;
                $display("FAIL underrun_cnt %0d: got %0d want %0d", p, underrun_cnt, exp_u[p]);
            end
            @(negedge mclk);
            checks++;
            if (underrun !== 1'b0) begin
                errors++;
                $display("FAIL underrun_width %0d: still high after one cycle", p);
            end
        end
        enable = 1'b0;
        checks++;
        if (pc[0] !== c0 + 8) begin
            errors++;
            $display("FAIL underrun_first: at %0d want %0d", pc[0], c0 + 8);
        end
        checks++;
        if (pc[2] - pc[1] !== 256 || pc[3] - pc[2] !== 256) begin
            errors++;
            $display("FAIL underrun_spacing: got %0d %0d want 256 256", pc[2] - pc[1], pc[3] - pc[2]);
        end
        checks++;
        if (sda_bad !== 0) begin
            errors++;
            $display("FAIL underrun_silence: sda high %0d cycles want 0", sda_bad);
        end
    endtask

    task automatic test_async_reset();
        int acc, t;
        send_beat(32'h1234_5678, acc);
        s_axis_tvalid = 1'b0;
        enable = 1'b1;
        fork
            begin
                send_beat(32'hDEAD_BEEF, acc);
                s_axis_tvalid = 1'b0;
            end
            capture(10);
        join
        checks++;
        if (s_axis_tready !== 1'b0 || bclk !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: tready %b bclk %b want 0 1", s_axis_tready, bclk);
        end
        checks++;
        if (word_at(1) >> 23 !== 32'h0000_0024) begin
            errors++;
            $display("FAIL rst_partial: got %h want 024", word_at(1) >> 23);
        end
        mclk_rstn = 1'b0;
        #1;
        checks++;
        if ({bclk, lrclk, sda, underrun} !== 4'b0000 || underrun_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rst_immediate: lines %b cnt %0d want 0000 0",
                     {bclk, lrclk, sda, underrun}, underrun_cnt);
        end
        @(negedge mclk);
        mclk_rstn = 1'b1;
        @(negedge mclk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL rst_tready: got %b want 1", s_axis_tready);
        end
        t = 0;
        while (underrun !== 1'b1 && t < 20) begin
            @(negedge mclk);
            t++;
        end
        enable = 1'b0;
        checks++;
        if (underrun !== 1'b1 || underrun_cnt !== 2'd1) begin
            errors++;
            $display("FAIL rst_discard: underrun %b cnt %0d want 1 1", underrun, underrun_cnt);
        end
    endtask

    task automatic test_enable_drop();
        int acc, ur0;
        logic [1:0] u0;
        @(negedge mclk);
        send_beat(32'h0F0F_F0F0, acc);
        s_axis_tvalid = 1'b0;
        enable = 1'b1;
        fork
            begin
                send_beat(32'hCAFE_1234, acc);
                s_axis_tvalid = 1'b0;
            end
            capture(21);
        join
        checks++;
        if (cap_lr[21] !== 1'b1) begin
            errors++;
            $display("FAIL drop_lr_before: got %b want 1", cap_lr[21]);
        end
        enable = 1'b0;
        u0 = underrun_cnt;
        ur0 = ur_seen;
        @(negedge mclk);
        checks++;
        if ({bclk, lrclk, sda} !== 3'b000) begin
            errors++;
            $display("FAIL drop_lines: got %b want 000", {bclk, lrclk, sda});
        end
        repeat (20) @(negedge mclk);
        checks++;
        if (s_axis_tready !== 1'b0 || underrun_cnt !== u0) begin
            errors++;
            $display("FAIL drop_hold: tready %b cnt %0d want 0 %0d", s_axis_tready, underrun_cnt, u0);
        end
        enable = 1'b1;
        capture(33);
        enable = 1'b0;
        checks++;
        if (word_at(1) !== 32'hCAFE_1234) begin
            errors++;
            $display("FAIL drop_resume_data: got %h want cafe1234", word_at(1));
        end
        checks++;
        if (lr_at(1) !== 32'h0001_FFFE) begin
            errors++;
            $display("FAIL drop_resume_lrclk: got %h want 0001fffe", lr_at(1));
        end
        @(negedge mclk);
        checks++;
        if (ur_seen !== ur0 || underrun_cnt !== 2'd1) begin
            errors++;
            $display("FAIL drop_underrun: pulses %0d cnt %0d want %0d 1", ur_seen, underrun_cnt, ur0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underrun();
        test_async_reset();
        test_enable_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
